flitzip_delta_encoder: RTL and testbench

- Stage directly downstream of the min/max reduction tree in the FlitZip compression path.
- Takes a 128-bit flit plus its per-byte min and max, and computes a base (min) and delta width from max-min.
- Subtracts the base from every chunk and packs the deltas LSB-first into a compressed payload.
- Two-stage registered pipeline with valid/ready handshakes on both sides; feeds the flit packetiser/serialiser.

---
 rtl/flitzip_pkg.sv | 33 +++
 rtl/flitzip_delta_encoder_if.sv | 29 ++
 rtl/flitzip_delta_pack.sv | 41 ++++
 rtl/flitzip_delta_encoder.sv | 103 ++++++++++
 tb/tb_flitzip_delta_encoder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flitzip_pkg.sv
// Shared constants, stage-1 record and delta-width helper for the FlitZip delta encoder.
package flitzip_pkg;

  localparam int NUM_OF_BITS = 128;
  localparam int CHUNK_SIZE  = 8;
  localparam int NUM_CHUNKS  = NUM_OF_BITS / CHUNK_SIZE;
  localparam int WIDTH_BITS  = 4;
  localparam int LEN_BITS    = 8;

  typedef struct packed {
    logic [NUM_OF_BITS-1:0] flit;
    logic [CHUNK_SIZE-1:0]  base;
    logic [WIDTH_BITS-1:0]  width;
  } s1_rec_t;

  // Bit length of (max - min); a reversed range is forced to the raw width.
  function automatic logic [WIDTH_BITS-1:0] delta_width(input logic [CHUNK_SIZE-1:0] min_val,
                                                        input logic [CHUNK_SIZE-1:0] max_val);
    logic [CHUNK_SIZE-1:0] range_val;
    logic [WIDTH_BITS-1:0] w;
    range_val = max_val - min_val;
    w = '0;
    if (max_val < min_val) begin
      w = WIDTH_BITS'(CHUNK_SIZE);
    end else begin
      for (int b = 0; b < CHUNK_SIZE; b++) begin
        if (range_val[b]) w = WIDTH_BITS'(b + 1);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/flitzip_delta_encoder_if.sv
// Upstream (flit + min/max) and downstream (encoded result) valid/ready bundle.
interface flitzip_delta_encoder_if;
  import flitzip_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_OF_BITS-1:0] input_data;
  logic [CHUNK_SIZE-1:0]  min_data;
  logic [CHUNK_SIZE-1:0]  max_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_OF_BITS-1:0] out_data;
  logic [CHUNK_SIZE-1:0]  out_base;
  logic [WIDTH_BITS-1:0]  out_width;
  logic [LEN_BITS-1:0]    out_len;
  logic                   out_compressed;

  modport slave (
    input  in_valid, input_data, min_data, max_data, out_ready,
    output in_ready, out_valid, out_data, out_base, out_width, out_len, out_compressed
  );

  modport master (
    output in_valid, input_data, min_data, max_data, out_ready,
    input  in_ready, out_valid, out_data, out_base, out_width, out_len, out_compressed
  );

endinterface

// File: rtl/flitzip_delta_pack.sv
// Combinational delta packer: subtracts the base from each chunk and packs W-bit deltas LSB-first.
module flitzip_delta_pack
  import flitzip_pkg::*;
(
  input  logic [NUM_OF_BITS-1:0] flit,
  input  logic [CHUNK_SIZE-1:0]  base,
  input  logic [WIDTH_BITS-1:0]  width,
  output logic [NUM_OF_BITS-1:0] pack_data,
  output logic [LEN_BITS-1:0]    len
);

  logic [CHUNK_SIZE-1:0] delta [NUM_CHUNKS];

  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_delta
      assign delta[gi] = flit[gi*CHUNK_SIZE +: CHUNK_SIZE] - base;
    end
  endgenerate

  // Widths at or above the chunk size (including out-of-range codes) pass the flit through raw.
  always_comb begin
    logic [6:0] idx;
    pack_data = '0;
    len       = LEN_BITS'(NUM_OF_BITS);
    idx       = '0;
    if (width >= WIDTH_BITS'(CHUNK_SIZE)) begin
      pack_data = flit;
    end else begin
      len = LEN_BITS'(NUM_CHUNKS * int'(width));
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        for (int b = 0; b < CHUNK_SIZE; b++) begin
          if (b < int'(width)) begin
            idx = 7'(i * int'(width) + b);
            pack_data[idx] = delta[i][b];
          end
        end
      end
    end
  end

endmodule

// File: rtl/flitzip_delta_encoder.sv
// Two-stage FlitZip delta encoder: stage 1 computes base/width, stage 2 packs deltas.
// Optional macro FLITZIP_STATS_EN adds stat_flits / stat_compressed output-handshake counters.
module flitzip_delta_encoder
  import flitzip_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  flitzip_delta_encoder_if.slave  bus
`ifdef FLITZIP_STATS_EN
  ,
  output logic [31:0]             stat_flits,
  output logic [31:0]             stat_compressed
`endif
);

  logic                   s1_valid_reg;
  s1_rec_t                s1_reg;
  s1_rec_t                s1_next;
  logic                   s1_adv;

  logic                   s2_valid_reg;
  logic [NUM_OF_BITS-1:0] out_data_reg;
  logic [CHUNK_SIZE-1:0]  out_base_reg;
  logic [WIDTH_BITS-1:0]  out_width_reg;
  logic [LEN_BITS-1:0]    out_len_reg;
  logic                   out_compressed_reg;

  logic [NUM_OF_BITS-1:0] pack_data;
  logic [LEN_BITS-1:0]    pack_len;
  logic                   compressed_next;

  // Ready is derived only from stage occupancy and out_ready, never from in_valid.
  assign s1_adv       = !s2_valid_reg || bus.out_ready;
  assign bus.in_ready = !s1_valid_reg || s1_adv;

  assign s1_next.flit  = bus.input_data;
  assign s1_next.base  = bus.min_data;
  assign s1_next.width = delta_width(bus.min_data, bus.max_data);

  flitzip_delta_pack u_pack (
    .flit      (s1_reg.flit),
    .base      (s1_reg.base),
    .width     (s1_reg.width),
    .pack_data (pack_data),
    .len       (pack_len)
  );

  assign compressed_next = (s1_reg.width < WIDTH_BITS'(CHUNK_SIZE));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg       <= 1'b0;
      s1_reg             <= '0;
      s2_valid_reg       <= 1'b0;
      out_data_reg       <= '0;
      out_base_reg       <= '0;
      out_width_reg      <= '0;
      out_len_reg        <= '0;
      out_compressed_reg <= 1'b0;
    end else begin
      if (bus.in_ready) begin
        s1_valid_reg <= bus.in_valid;
        if (bus.in_valid) s1_reg <= s1_next;
      end
      if (s1_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_data_reg       <= pack_data;
          out_base_reg       <= compressed_next ? s1_reg.base : '0;
          out_width_reg      <= compressed_next ? s1_reg.width : WIDTH_BITS'(CHUNK_SIZE);
          out_len_reg        <= pack_len;
          out_compressed_reg <= compressed_next;
        end
      end
    end
  end

  assign bus.out_valid      = s2_valid_reg;
  assign bus.out_data       = out_data_reg;
  assign bus.out_base       = out_base_reg;
  assign bus.out_width      = out_width_reg;
  assign bus.out_len        = out_len_reg;
  assign bus.out_compressed = out_compressed_reg;

`ifdef FLITZIP_STATS_EN
  logic [31:0] stat_flits_reg;
  logic [31:0] stat_compressed_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits_reg      <= '0;
      stat_compressed_reg <= '0;
    end else if (s2_valid_reg && bus.out_ready) begin
      stat_flits_reg <= stat_flits_reg + 32'd1;
      if (out_compressed_reg) stat_compressed_reg <= stat_compressed_reg + 32'd1;
    end
  end

  assign stat_flits      = stat_flits_reg;
  assign stat_compressed = stat_compressed_reg;
`endif

endmodule

// File: tb/tb_flitzip_delta_encoder.sv
// Self-checking bench for flitzip_delta_encoder: vector table, scoreboard queue, stall/reset sequences.
module tb_flitzip_delta_encoder;

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   base;
    logic [3:0]   width;
    logic [7:0]   len;
    logic         comp;
  } exp_t;

  typedef struct packed {
    logic [127:0] flit;
    logic [7:0]   mn;
    logic [7:0]   mx;
    exp_t         e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flitzip_delta_encoder_if bus();

`ifdef FLITZIP_STATS_EN
  logic [31:0] stat_flits;
  logic [31:0] stat_compressed;
`endif

  flitzip_delta_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FLITZIP_STATS_EN
    ,
    .stat_flits      (stat_flits),
    .stat_compressed (stat_compressed)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Independent reference: accumulate deltas from the top chunk down by shifting.
  function automatic exp_t model(input logic [127:0] f, input logic [7:0] mn, input logic [7:0] mx);
    exp_t e;
    int w;
    logic [7:0] r;
    logic [127:0] acc;
    if (mx < mn) w = 8;
    else begin
      r = mx - mn;
      w = 0;
      while (w < 8 && (r >> w) != 8'd0) w++;
    end
    if (w == 8) begin
      e.data = f; e.base = 8'h00; e.width = 4'd8; e.len = 8'd128; e.comp = 1'b0;
    end else begin
      acc = '0;
      for (int i = 15; i >= 0; i--) begin
        logic [7:0] d;
        logic [7:0] m;
        d = f[i*8 +: 8] - mn;
        m = 8'((9'd1 << w) - 9'd1);
        acc = (acc << w) | {120'd0, d & m};
      end
      e.data = acc; e.base = mn; e.width = 4'(w); e.len = 8'(16 * w); e.comp = 1'b1;
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [127:0] f, input logic [7:0] mn, input logic [7:0] mx, input exp_t e);
    bit ok = 0;
    bus.in_valid   = 1'b1;
    bus.input_data = f;
    bus.min_data   = mn;
    bus.max_data   = mx;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        sb.push_back(e);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, 128'(sb.size()), 128'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      exp_t act;
      act = '{bus.out_data, bus.out_base, bus.out_width, bus.out_len, bus.out_compressed};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        $display("TXN %0d data=%032h base=%02h w=%0d len=%0d comp=%0b", n_out,
                 act.data, act.base, act.width, act.len, act.comp);
        if (act !== e) begin
          errors++;
          $display("FAIL txn_%0d actual=%0h/%0h/%0d/%0d/%0b required=%0h/%0h/%0d/%0d/%0b", n_out,
                   act.data, act.base, act.width, act.len, act.comp,
                   e.data, e.base, e.width, e.len, e.comp);
        end
        n_out++;
      end
    end
  end

  initial begin
    bit stream_done;
    bit rand_done;
    int stat_idx[10];

    vecs[0] = '{{16{8'h05}}, 8'h05, 8'h05, '{128'd0, 8'h05, 4'd0, 8'd0, 1'b1}};
    vecs[1] = '{{8{16'h1310}}, 8'h10, 8'h13, '{128'h0000_0000_0000_0000_0000_0000_CCCC_CCCC, 8'h10, 4'd2, 8'd32, 1'b1}};
    vecs[2] = '{{8{16'hFF00}}, 8'h00, 8'hFF, '{{8{16'hFF00}}, 8'h00, 4'd8, 8'd128, 1'b0}};
    vecs[3] = '{{8{16'h2120}}, 8'h20, 8'h21, '{128'h0000_0000_0000_0000_0000_0000_0000_AAAA, 8'h20, 4'd1, 8'd16, 1'b1}};
    vecs[4] = '{{8{16'h8000}}, 8'h00, 8'h80, '{{8{16'h8000}}, 8'h00, 4'd8, 8'd128, 1'b0}};
    vecs[5] = '{{16{8'h10}}, 8'h10, 8'h05, '{{16{8'h10}}, 8'h00, 4'd8, 8'd128, 1'b0}};
    vecs[6] = '{{{15{8'h7F}}, 8'h00}, 8'h00, 8'h7F, '{128'h0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF80, 8'h00, 4'd7, 8'd112, 1'b1}};
    vecs[7] = '{{{14{8'h35}}, 8'h3A, 8'h30}, 8'h30, 8'h3A, '{128'h0000_0000_0000_0000_5555_5555_5555_55A0, 8'h30, 4'd4, 8'd64, 1'b1}};
    stat_idx = '{0, 1, 3, 6, 7, 0, 2, 4, 5, 2};

    bus.in_valid   = 1'b0;
    bus.input_data = '0;
    bus.min_data   = '0;
    bus.max_data   = '0;
    bus.out_ready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_data", bus.out_data, 128'd0);
    check("rst_out_base", 128'(bus.out_base), 128'd0);
    check("rst_out_width", 128'(bus.out_width), 128'd0);
    check("rst_out_len", 128'(bus.out_len), 128'd0);
    check("rst_out_comp", 128'(bus.out_compressed), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Latency: out_valid appears on the second edge after the accepting edge
    send(vecs[0].flit, vecs[0].mn, vecs[0].mx, vecs[0].e);
    @(negedge clk);
    check("lat_cycle1_valid", 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 128'(bus.out_valid), 128'd1);
    @(posedge clk);
    #1;
    drain("drain_latency");

    // Table, back-to-back
    for (int k = 0; k < 8; k++) send(vecs[k].flit, vecs[k].mn, vecs[k].mx, vecs[k].e);
    drain("drain_table");

    // Backpressure: only two flits fit, then in_ready drops and data holds
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    stream_done = 0;
    fork
      begin
        for (int k = 1; k < 5; k++) send(vecs[k].flit, vecs[k].mn, vecs[k].mx, vecs[k].e);
        stream_done = 1;
      end
    join_none
    repeat (6) @(negedge clk);
    check("stall_in_ready", 128'(bus.in_ready), 128'd0);
    check("stall_accepted", 128'(sb.size()), 128'd2);
    check("stall_out_valid", 128'(bus.out_valid), 128'd1);
    repeat (3) @(negedge clk);
    check("stall_data_hold", bus.out_data, vecs[1].e.data);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int t = 0; t < 200 && !stream_done; t++) @(posedge clk);
    check("stall_stream_done", 128'(stream_done), 128'd1);
    #1;
    drain("drain_stall");

    // Reset with both stages full discards both flits
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(vecs[6].flit, vecs[6].mn, vecs[6].mx, vecs[6].e);
    send(vecs[7].flit, vecs[7].mn, vecs[7].mx, vecs[7].e);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_stale", 128'(bus.out_valid), 128'd0);
    @(posedge clk);
    #1;

    // Random stream with random backpressure
    rand_done = 0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int n = 0; n < 40; n++) begin
      logic [127:0] f;
      logic [7:0] b, c, mn, mx;
      int w, span;
      w = int'($urandom_range(0, 8));
      b = 8'($urandom_range(0, 255));
      span = (1 << w) - 1;
      if (span > 255 - int'(b)) span = 255 - int'(b);
      mn = 8'hFF;
      mx = 8'h00;
      for (int i = 0; i < 16; i++) begin
        c = 8'(int'(b) + int'($urandom_range(0, span)));
        f[i*8 +: 8] = c;
        if (c < mn) mn = c;
        if (c > mx) mx = c;
      end
      send(f, mn, mx, model(f, mn, mx));
    end
    rand_done = 1;
    repeat (2) @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain("drain_random");

`ifdef FLITZIP_STATS_EN
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("stat_flits_reset", 128'(stat_flits), 128'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++)
      send(vecs[stat_idx[k]].flit, vecs[stat_idx[k]].mn, vecs[stat_idx[k]].mx, vecs[stat_idx[k]].e);
    drain("drain_stats");
    @(negedge clk);
    check("stat_flits", 128'(stat_flits), 128'd10);
    check("stat_compressed", 128'(stat_compressed), 128'd6);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
